// File: rtl/phase_timer.sv
// Phase-duration timer: looks up per-phase cycle count, counts down (pausable/abortable), pulses done.
// Latency: count visible one edge after accepted start; busy spans N+1 cycles plus paused cycles.
// Backpressure: none; start ignored while busy. PHASE_TIMER_WR_EN adds a 32-entry override RAM.
module phase_timer #(
    parameter int unsigned COUNT_W   = 32,
    parameter int unsigned SCALE     = 1,
    parameter int unsigned BASE_FILL = 120,
    parameter int unsigned BASE_WASH = 300,
    parameter int unsigned BASE_SPIN = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         clk_freq,
    input  logic [2:0]         phase,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
`ifdef PHASE_TIMER_WR_EN
    input  logic               wr_en,
    input  logic [4:0]         wr_addr,
    input  logic [COUNT_W-1:0] wr_data,
`endif
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] remaining,
    output logic [2:0]         phase_q
);

    // Largest table entry is the largest base at clk_freq=3.
    localparam longint unsigned MAX_BASE_FW = (BASE_FILL > BASE_WASH) ? BASE_FILL : BASE_WASH;
    localparam longint unsigned MAX_BASE    = (MAX_BASE_FW > BASE_SPIN) ? MAX_BASE_FW : BASE_SPIN;
    localparam longint unsigned MAX_ENTRY   = ((MAX_BASE << 3) * SCALE) - 64'd2;

    if (COUNT_W < 64 && MAX_ENTRY >= (64'd1 << COUNT_W)) begin : g_fit_check
        $error("phase_timer: COUNT_W too narrow for largest table entry");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [COUNT_W-1:0] remaining_nx;
    logic [2:0]         phase_q_nx;
    logic               done_nx;
    logic [COUNT_W-1:0] load_val;

    function automatic logic [COUNT_W-1:0] table_entry(input logic [2:0] ph, input logic [1:0] fq);
        logic [63:0] base;
        logic [63:0] full;
        base = 64'd0;
        case (ph)
            3'b001, 3'b111: base = 64'(BASE_FILL);
            3'b011:         base = 64'(BASE_WASH);
            3'b110:         base = 64'(BASE_SPIN);
            default:        base = 64'd0;
        endcase
        if (base == 64'd0)
            full = 64'd1;
        else
            full = ((base << fq) * 64'(SCALE)) - 64'd2;
        return COUNT_W'(full);
    endfunction

`ifdef PHASE_TIMER_WR_EN
    logic [COUNT_W-1:0] ovr_mem [32];
    logic [31:0]        ovr_vld;
    logic [4:0]         rd_addr;

    assign rd_addr = {phase, clk_freq};

    // Read happens before the same-edge write lands, so start sees the old contents.
    assign load_val = ovr_vld[rd_addr] ? ovr_mem[rd_addr] : table_entry(phase, clk_freq);

    always_ff @(posedge clk) begin
        if (wr_en)
            ovr_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovr_vld <= '0;
        else if (wr_en)
            ovr_vld[wr_addr] <= 1'b1;
    end
`else
    assign load_val = table_entry(phase, clk_freq);
`endif

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        phase_q_nx   = phase_q;
        done_nx      = 1'b0;
        if (abort) begin
            state_nx     = IDLE;
            remaining_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nx     = RUN;
                        remaining_nx = load_val;
                        phase_q_nx   = phase;
                    end
                end
                // A resume edge counts like a running edge, so each paused cycle costs exactly one.
                RUN, PAUSE: begin
                    if (pause) begin
                        state_nx = PAUSE;
                    end else if (remaining == '0) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx     = RUN;
                        remaining_nx = remaining - COUNT_W'(1);
                    end
                end
                default: begin
                    state_nx     = IDLE;
                    remaining_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            phase_q   <= 3'b000;
        end else begin
            state     <= state_nx;
            busy      <= (state_nx != IDLE);
            done      <= done_nx;
            remaining <= remaining_nx;
            phase_q   <= phase_q_nx;
        end
    end

endmodule
